// File: rtl/relu_stream_sequencer_pkg.sv
// dla_act_pkg: shared FSM state encoding and activation constants for the ReLU stream sequencer
package dla_act_pkg;
  localparam int ACC_W = 24;
  localparam int ACT_W = 8;
  localparam int PACK = 4;
  localparam int LEN_W = 16;
  localparam int PACK_W = ACT_W * PACK;
  localparam int ACT_MAX = 127;
  localparam int ACT_MIN = 0;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/relu_stream_sequencer_if.sv
// relu_stream_sequencer_if: control, accumulator input stream and packed activation output stream
// master: drives start/len, in_valid/in_data and out_ready
// slave: the sequencer; drives busy/done, in_ready and out_valid/out_data/out_keep/out_last
interface relu_stream_sequencer_if #(
  parameter int ACC_W = dla_act_pkg::ACC_W,
  parameter int ACT_W = dla_act_pkg::ACT_W,
  parameter int PACK = dla_act_pkg::PACK,
  parameter int LEN_W = dla_act_pkg::LEN_W
);
  logic start;
  logic [LEN_W-1:0] len;
  logic busy;
  logic done;
  logic in_valid;
  logic in_ready;
  logic [ACC_W-1:0] in_data;
  logic out_valid;
  logic out_ready;
  logic [ACT_W*PACK-1:0] out_data;
  logic [PACK-1:0] out_keep;
  logic out_last;
  modport master (
    output start, len, in_valid, in_data, out_ready,
    input busy, done, in_ready, out_valid, out_data, out_keep, out_last
  );
  modport slave (
    input start, len, in_valid, in_data, out_ready,
    output busy, done, in_ready, out_valid, out_data, out_keep, out_last
  );
endinterface

// File: rtl/relu_stream_sequencer_relu.sv
// ReLU: clamps a signed accumulator value to the activation range [ACT_MIN, ACT_MAX]
// in_data: signed accumulator input; act: clamped activation
module ReLU #(
  parameter int ACC_W = 24,
  parameter int ACT_W = 8
) (
  input  logic [ACC_W-1:0] in_data,
  output logic [ACT_W-1:0] act
);
  import dla_act_pkg::*;
  // the sign bit is tested first, so the magnitude compare only ever sees non-negative values
  always_comb act = in_data[ACC_W-1] ? ACT_W'(ACT_MIN) :
                    (in_data > ACC_W'(ACT_MAX)) ? ACT_W'(ACT_MAX) : in_data[ACT_W-1:0];
endmodule

// File: rtl/relu_stream_sequencer.sv
// relu_stream_sequencer: runs a block of accumulator values through ReLU and packs PACK activations per output word
// clk/rst: rising-edge clock, synchronous active-high reset
// bus.start/len/busy/done: block control; bus.in_*: accumulator stream; bus.out_*: packed activation stream
module relu_stream_sequencer #(
  parameter int ACC_W = 24,
  parameter int ACT_W = 8,
  parameter int PACK = 4,
  parameter int LEN_W = 16
) (
  input logic clk,
  input logic rst,
  relu_stream_sequencer_if.slave bus
);
  import dla_act_pkg::*;
  localparam int LW = $clog2(PACK);
  localparam int PW = ACT_W * PACK;
  state_t state, state_n;
  logic [LW-1:0] lane;
  logic [LEN_W-1:0] remaining;
  logic [PW-1:0] pack_q, word;
  logic [ACT_W-1:0] act;
  logic [PACK-1:0] keep;
  logic busy_q, done_q, last_in, stall, accept, flush, start_ok;
  ReLU #(.ACC_W(ACC_W), .ACT_W(ACT_W)) u_relu (.in_data(bus.in_data), .act(act));
  // the next accepted input closes a word: either the lane is full or it is the block's last element
  assign last_in = lane == LW'(PACK - 1) || remaining == LEN_W'(1);
  assign stall = bus.out_valid && !bus.out_ready && last_in;
  assign bus.in_ready = state == RUN && !stall;
  assign accept = bus.in_valid && bus.in_ready;
  assign flush = accept && last_in;
  // busy_q also covers the done cycle, so a start arriving alongside done is ignored
  assign start_ok = state == IDLE && !busy_q && bus.start;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign keep = {PACK{1'b1}} >> (LW'(PACK - 1) - lane);
  always_comb begin
    word = pack_q;
    word[lane*ACT_W +: ACT_W] = act;
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (start_ok) state_n = bus.len == '0 ? DONE : RUN;
      RUN: if (accept && remaining == LEN_W'(1)) state_n = DRAIN;
      DRAIN: if (bus.out_valid && bus.out_ready && bus.out_last) state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lane <= '0;
      remaining <= '0;
      pack_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data <= '0;
      bus.out_keep <= '0;
      bus.out_last <= 1'b0;
    end else begin
      state <= state_n;
      // done is registered one cycle behind the DONE state; busy stays high through it
      busy_q <= state_n != IDLE || state == DONE;
      done_q <= state == DONE;
      if (start_ok) remaining <= bus.len;
      else if (accept) remaining <= remaining - 1'b1;
      if (bus.out_valid && bus.out_ready) bus.out_valid <= 1'b0;
      // a flush only happens when the output register is empty or being drained this cycle
      if (flush) begin
        bus.out_valid <= 1'b1;
        bus.out_data <= word;
        bus.out_keep <= keep;
        bus.out_last <= remaining == LEN_W'(1);
        pack_q <= '0;
        lane <= '0;
      end else if (accept) begin
        pack_q <= word;
        lane <= lane + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_relu_stream_sequencer.sv
// tb_relu_stream_sequencer: scoreboard bench for relu_stream_sequencer
module tb_relu_stream_sequencer;
  typedef struct packed {
    logic [31:0] d;
    logic [3:0] k;
    logic l;
  } word_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  relu_stream_sequencer_if bus();
  relu_stream_sequencer dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int n_checks = 0;
  int n_fails = 0;
  word_t exp_q[$];
  word_t prev;
  logic [31:0] last_word = '0;
  int cyc = 0, done_cnt = 0, busy_cnt = 0, ov_cnt = 0, last_hs = 0, hold = 0, stalls = 0;
  bit hs_seen = 1'b0, arm = 1'b0, pv_stall = 1'b0;
  int vals[$];
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] relu_m(input int v);
    return v < 0 ? 8'd0 : v > 127 ? 8'd127 : 8'(v);
  endfunction
  always @(negedge clk) begin
    if (arm && bus.out_valid) begin
      hold = 5;
      arm = 1'b0;
    end
    bus.out_ready = hold == 0;
    if (hold > 0) hold--;
    #2;
    cyc++;
    if (bus.busy) busy_cnt++;
    if (bus.out_valid) ov_cnt++;
    if (bus.done) begin
      done_cnt++;
      if (hs_seen) check("done_latency", cyc - last_hs, 2);
      hs_seen = 1'b0;
    end
    if (pv_stall) begin
      check("hold_valid", bus.out_valid, 1);
      check("hold_word", {bus.out_data, bus.out_keep, bus.out_last}, prev);
    end
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) check("unexpected_word", exp_q.size(), 1);
      else begin
        word_t e;
        e = exp_q.pop_front();
        check("out_data", bus.out_data, e.d);
        check("out_keep", bus.out_keep, e.k);
        check("out_last", bus.out_last, e.l);
        last_word = bus.out_data;
        if (bus.out_last) begin
          last_hs = cyc;
          hs_seen = 1'b1;
        end
      end
    end
    pv_stall = bus.out_valid && !bus.out_ready;
    prev = {bus.out_data, bus.out_keep, bus.out_last};
  end
  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_in_ready"}, bus.in_ready, 0);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_out_last"}, bus.out_last, 0);
    check({tag, "_out_data"}, bus.out_data, 0);
    check({tag, "_out_keep"}, bus.out_keep, 0);
  endtask
  task automatic run_block(input int n, input int abort_at, input int inject_at, input bit do_hold, input string tag);
    int i = 0;
    int guard = 0;
    int d0;
    word_t w;
    if (abort_at < 0)
      for (int b = 0; b < n; b += 4) begin
        w = '0;
        for (int j = 0; j < 4; j++)
          if (b + j < n) begin
            w.d[8*j +: 8] = relu_m(vals[b+j]);
            w.k[j] = 1'b1;
          end
        w.l = b + 4 >= n;
        exp_q.push_back(w);
      end
    d0 = done_cnt;
    busy_cnt = 0;
    ov_cnt = 0;
    stalls = 0;
    arm = do_hold;
    @(negedge clk);
    bus.start = 1'b1;
    bus.len = 16'(n);
    @(negedge clk);
    bus.start = 1'b0;
    while (i < n && guard < 1000 && !(abort_at >= 0 && i == abort_at)) begin
      guard++;
      bus.in_valid = 1'b1;
      bus.in_data = 24'(vals[i]);
      bus.start = i == inject_at;
      bus.len = i == inject_at ? 16'd3 : 16'(n);
      #1;
      if (bus.in_ready) i++;
      else stalls++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.start = 1'b0;
    check({tag, "_inputs_taken"}, i, abort_at >= 0 ? abort_at : n);
    if (abort_at >= 0) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #3;
      check_reset_outputs({tag, "_abort"});
      repeat (6) @(negedge clk);
      check({tag, "_no_done"}, done_cnt - d0, 0);
      check({tag, "_no_word"}, ov_cnt, 0);
    end else begin
      guard = 0;
      while (done_cnt == d0 && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      repeat (4) @(negedge clk);
      check({tag, "_done_count"}, done_cnt - d0, 1);
      check({tag, "_words_left"}, exp_q.size(), 0);
    end
  endtask
  initial begin
    bus.start = 1'b0;
    bus.len = '0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #3;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    vals = '{5, 200, -5, 65535};
    run_block(4, -1, -1, 1'b0, "t1");
    check("t1_word", last_word, 32'h7F007F05);
    check("t1_no_stall", stalls, 0);
    vals = '{1, 2, 3, 4, 5, 6};
    run_block(6, -1, -1, 1'b0, "t2");
    check("t2_last_word", last_word, 32'h00000605);
    vals = '{10, -20, 130, 127, 128, 0, -1, 77};
    run_block(8, -1, -1, 1'b1, "t3");
    check("t3_stalled", stalls > 0, 1);
    vals = '{};
    run_block(0, -1, -1, 1'b0, "t4");
    check("t4_busy_cycles", busy_cnt, 2);
    check("t4_no_out_valid", ov_cnt, 0);
    vals = '{3, 9, -100, 1000, 50, 60, 70, 80};
    run_block(8, -1, 2, 1'b0, "t5");
    check("t5_last_word", last_word, 32'h50463C32);
    vals = '{11, 22, 33, 44, 55, 66, 77, 88};
    run_block(8, 3, -1, 1'b0, "t6");
    vals = '{10, -1, 300, 42};
    run_block(4, -1, -1, 1'b0, "t6b");
    check("t6b_word", last_word, 32'h2A7F000A);
    vals = '{};
    for (int i = 0; i < 11; i++) vals.push_back(int'($urandom_range(400)) - 200);
    run_block(11, -1, -1, 1'b0, "rand");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/relu_stream_sequencer.md
Name: relu_stream_sequencer

Overview:
- Sequences a block of accumulator results from the PE array through the ReLU activation unit and packs the 8-bit activations into 32-bit words for the activation buffer.
- Software or the layer controller issues `start` with an element count. The block then handshakes inputs one at a time, applies ReLU, packs PACK lanes per word and flags the final word.
- Sits between the accumulator drain path and the activation SRAM write port.

Parameters:
- ACC_W, 24, accumulator/ReLU input width (signed)
- ACT_W, 8, activation/ReLU output width (signed)
- PACK, 4, activations per output word
- LEN_W, 16, width of the element-count field

Ports:
- clk  in  1  clock; all logic is on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a block; honoured only in IDLE
- len  in  LEN_W  number of elements in the block, sampled with start
- busy  out  1  high from the accepted start until the done pulse, inclusive
- done  out  1  one-cycle pulse when the block completes
- in_valid  in  1  accumulator word valid
- in_ready  out  1  sequencer accepts in_data this cycle
- in_data  in  ACC_W  signed accumulator value
- out_valid  out  1  packed word valid
- out_ready  in  1  downstream accepts the word
- out_data  out  ACT_W*PACK  packed activations; lane 0 is in bits [ACT_W-1:0]
- out_keep  out  PACK  per-lane valid mask
- out_last  out  1  marks the final word of the block

Behaviour:
- Reset: state=IDLE; busy, done, in_ready, out_valid, out_last = 0; out_data, out_keep = 0; lane index = 0; remaining count = 0.
- ReLU mapping, applied in the ReLU sub-module:
  - in<0 gives 0
  - in>127 gives 127
  - otherwise in[7:0]
- FSM states:
  - IDLE:
    - start with len!=0: latch len into remaining, go to RUN.
    - start with len==0: go to DONE; no output words are produced.
  - RUN:
    - An input is accepted when in_valid && in_ready.
    - The activation is written into the pack-register lane given by the lane index, and remaining is decremented.
    - If lane==PACK-1 or remaining==1, the pack register moves to the output register in the same cycle:
      - out_valid=1 next cycle
      - out_keep = lanes written
      - out_last = 1 if remaining was 1
      - lane index resets to 0
    - Otherwise the lane index increments.
  - DRAIN: entered after the last input is accepted. Wait until the word with out_last completes its handshake (out_valid && out_ready), then go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE. busy drops in the cycle after done.
- in_ready = (state==RUN) && !stall, where stall = out_valid && !out_ready && (lane==PACK-1 || remaining==1).
  - in_ready does not depend combinationally on in_valid.
- Latency: the input that completes a word produces out_valid on the next clock edge.
- Output hold: while out_valid && !out_ready, out_data, out_keep and out_last stay stable. out_valid deasserts only after a handshake.
- Packing: a partial final word has unwritten lanes zeroed. For example, len=6 gives word 1 with out_keep=4'b1111 and word 2 with out_keep=4'b0011.
- A handshake on the output and a new word load in the same cycle is legal; the output register updates with no bubble.
- start asserted while busy is ignored and has no side effects.
- rst mid-block aborts immediately. All state clears, with no done pulse and no partial word emitted.
- Widths:
  - remaining uses LEN_W bits, so the maximum block is 2^LEN_W-1 elements.
  - The lane index uses $clog2(PACK) bits.

Decomposition:
- Shared package `dla_act_pkg`:
  - state enum: IDLE, RUN, DRAIN, DONE
  - localparams ACT_MAX=127 and ACT_MIN=0
  - PACK_W = ACT_W*PACK
- Sub-module: the existing `ReLU` combinational unit, instantiated once on in_data.
- Packing and handshake logic stays in the top module.

Test Plan:
- len=4, inputs 5, 200, -5, 65535, out_ready=1 → one word with lanes {127, 0, 127, 5} (lane 3 to lane 0), i.e. out_data=32'h7F007F05. out_keep=4'hF, out_last=1; done pulses two cycles after the word handshake.
- len=6, inputs 1..6 → word 1 = 32'h04030201 with keep F and last 0; word 2 = 32'h00000605 with keep 3 and last 1; exactly one done pulse.
- len=8 with out_ready held low for 5 cycles after the first word → in_ready drops on lane 3 of word 2; out_data is stable throughout; no data is lost once out_ready rises.
- len=0 start → busy high for 2 cycles, done pulses once, out_valid never asserts.
- start pulse during RUN with a different len → ignored; the original count completes.
- rst asserted after 3 of 8 inputs → all outputs return to reset values the next cycle; no done pulse; a new start with len=4 then completes normally.
